tohost_monitor: RTL and testbench
=================================

# tohost_monitor

Simulation-side HTIF end-of-test detector for the Starship SoC harness. Snoops the harness memory write stream, keeps a byte-merged shadow of the `tohost` word, decodes exit and command values, and produces the `tohost`/pass/fail/timeout status the top-level testbench consumes in place of its tied-off `tohost` wire. Also acknowledges non-exit commands by clearing `tohost` after a fixed delay, emulating the host side.

## Interface
- `TOHOST_ADDR`, default `32'h8000_1000`: byte address of the 64-bit `tohost` word, 8-byte aligned.
- `ACK_DELAY`, default `4`: cycles from command decode to host clear of `tohost`. Range 1..255.
- `clock`  in  1  simulation clock.
- `reset`  in  1  synchronous, active-low.
- `wr_valid`  in  1  write beat valid.
- `wr_ready`  out  1  write beat accepted when `wr_valid && wr_ready`.
- `wr_addr`  in  32  byte address, 8-byte aligned.
- `wr_data`  in  64  write data.
- `wr_mask`  in  8  byte enables.
- `max_cycles`  in  64  timeout limit; 0 disables.
- `tohost`  out  64  shadow `tohost` value.
- `cmd_valid`  out  1  one-cycle pulse: non-exit command decoded.
- `cmd_data`  out  64  command value, valid with `cmd_valid`.
- `done`  out  1  sticky: test finished.
- `pass`  out  1  sticky: `tohost == 1` at exit.
- `fail`  out  1  sticky: exit code non-zero or timeout.
- `timeout`  out  1  sticky: failure caused by cycle limit.
- `exit_code`  out  63  `tohost[63:1]` captured at exit.
- `cycle_count`  out  64  cycles since reset release.

## Operation
- Reset (`reset == 0` at a rising edge): state IDLE; all outputs 0 except `wr_ready = 1`; shadow and counter cleared.
- States: IDLE, EVAL, ACK_WAIT, DONE.
- IDLE: `wr_ready = 1`. An accepted beat with `wr_addr == TOHOST_ADDR` merges the bytes selected by `wr_mask` into the shadow. Next state is EVAL if the merged value is non-zero, otherwise IDLE. Beats to other addresses are accepted and ignored.
- EVAL (1 cycle, `wr_ready = 0`):
  - Shadow bit0 = 1 (exit): latch `exit_code = shadow[63:1]`, set `pass = (shadow == 1)` and `fail = !pass`, set `done`, go to DONE.
  - Bit0 = 0 (command): pulse `cmd_valid` with `cmd_data = shadow`, load the ack counter with `ACK_DELAY`, go to ACK_WAIT.
- ACK_WAIT: `wr_ready = 0`. The counter decrements each cycle. When it reaches 0, clear the shadow and go to IDLE.
- DONE: terminal until reset. `wr_ready = 1`; all beats are accepted and dropped. Shadow, flags, and `cycle_count` are frozen.
- Timeout: `cycle_count` increments every cycle the state is not DONE, saturating at all-ones. In IDLE, if `max_cycles != 0 && cycle_count >= max_cycles` and no `tohost` beat is accepted that cycle, set `timeout`, `fail`, `done`, go to DONE. `exit_code` stays 0.
- A zero-mask beat to `TOHOST_ADDR` is accepted and leaves the shadow unchanged. It re-evaluates only if the shadow is already non-zero.

## Timing
- A `tohost` beat accepted at edge N gives shadow visible after N, EVAL in cycle N+1, and `done`/`pass`/`fail` or `cmd_valid` visible after edge N+1.
- A command returns to IDLE `ACK_DELAY + 1` edges after EVAL; `tohost` reads 0 in the first IDLE cycle.
- Timeout and `tohost` beat in the same IDLE cycle: the beat wins and timeout is suppressed. The limit is re-checked on the next IDLE cycle.
- Reset asserted in any state (including mid ACK_WAIT or DONE) returns to the reset values at the next edge. A pending ack is discarded.

## Configuration
- `TOHOST_VARIANT_CMP_EN`: when defined, adds inputs `variant_done` (1) and `variant_tohost` (64), and output `variant_mismatch` (1, sticky, reset 0).
  - Set `variant_mismatch` once both `done` and `variant_done` are 1 and `variant_tohost != tohost` at that point. Evaluate it once, at the first cycle both are high.
  - This is used for taint-divergence detection between the DUT and variant harness instances.
- When not defined, the ports are absent and there is no extra logic.

## Test plan
- Write `0x1` full mask to `TOHOST_ADDR` at edge N -> `done = pass = 1` and `fail = 0` after N+1; `exit_code = 0`.
- Write `0x7` -> `fail = 1`, `exit_code = 3`, `pass = 0`. A later write of `0x1` does not change the outputs.
- Write `0x0000_0000_0101_0000` with `ACK_DELAY = 4` -> `cmd_valid` pulses after N+1 with that data. `wr_ready` is 0 for 5 cycles, then `tohost = 0`, `wr_ready = 1`.
- Split write: mask `0x0F` data `0x3`, then mask `0xF0` data `0x5 << 32`. The first is evaluated as exit (`exit_code = 1`, `fail = 1`); the second beat is dropped in DONE.
- `max_cycles = 100`, no writes -> `timeout = fail = done = 1` once `cycle_count` reaches 100. A `tohost` beat in that same cycle instead yields a normal exit.
- Hold `reset` low for 1 cycle during ACK_WAIT -> all outputs return to 0, `wr_ready = 1`, no stale clear. With `TOHOST_VARIANT_CMP_EN`: DUT exits `0x1`, variant `0x3` -> `variant_mismatch = 1`.

Source files
------------

// File: rtl/tohost_monitor.sv
// HTIF tohost snooper: byte-merged tohost shadow, exit/command decode, host ack, cycle timeout.
// Optional TOHOST_VARIANT_CMP_EN adds a sticky compare against a variant harness tohost.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
    parameter int unsigned ACK_DELAY   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_mask,
    input  logic [63:0] max_cycles,
    output logic [63:0] tohost,
    output logic        cmd_valid,
    output logic [63:0] cmd_data,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [62:0] exit_code,
    output logic [63:0] cycle_count
`ifdef TOHOST_VARIANT_CMP_EN
    ,
    input  logic        variant_done,
    input  logic [63:0] variant_tohost,
    output logic        variant_mismatch
`endif
);

    // state    | meaning
    // ---------+--------------------------------------------------
    // IDLE     | accepting beats, merging tohost, watching limit
    // EVAL     | one cycle: decode shadow as exit or command
    // ACK_WAIT | host-side delay before clearing tohost
    // DONE     | test finished; everything frozen until reset
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVAL     = 2'd1,
        S_ACK_WAIT = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    localparam logic [7:0] ACK_LOAD = 8'(ACK_DELAY);

    state_t      state;
    logic [63:0] shadow;
    logic [7:0]  ack_cnt;
    logic [63:0] merged;
    logic        tohost_hit;
    logic        limit_hit;

    always_comb begin
        merged = shadow;
        for (int i = 0; i < 8; i++) begin
            if (wr_mask[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    assign tohost_hit = (state == S_IDLE) && wr_valid && (wr_addr == TOHOST_ADDR);
    assign limit_hit  = (max_cycles != 64'd0) && (cycle_count >= max_cycles);
    assign tohost     = shadow;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            shadow      <= '0;
            ack_cnt     <= '0;
            wr_ready    <= 1'b1;
            cmd_valid   <= 1'b0;
            cmd_data    <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            cycle_count <= '0;
        end else begin
            cmd_valid <= 1'b0;
            if (state != S_DONE && cycle_count != '1) cycle_count <= cycle_count + 64'd1;

            case (state)
                S_IDLE: begin
                    // A tohost beat takes priority over the limit check this cycle.
                    if (tohost_hit) begin
                        shadow <= merged;
                        if (merged != 64'd0) begin
                            state    <= S_EVAL;
                            wr_ready <= 1'b0;
                        end
                    end else if (limit_hit) begin
                        timeout <= 1'b1;
                        fail    <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_EVAL: begin
                    if (shadow[0]) begin
                        exit_code <= shadow[63:1];
                        pass      <= (shadow == 64'd1);
                        fail      <= (shadow != 64'd1);
                        done      <= 1'b1;
                        wr_ready  <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cmd_valid <= 1'b1;
                        cmd_data  <= shadow;
                        ack_cnt   <= ACK_LOAD;
                        state     <= S_ACK_WAIT;
                    end
                end
                S_ACK_WAIT: begin
                    ack_cnt <= ack_cnt - 8'd1;
                    if (ack_cnt == 8'd1) begin
                        shadow   <= '0;
                        wr_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state    <= S_IDLE;
                    wr_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef TOHOST_VARIANT_CMP_EN
    logic variant_checked;

    always_ff @(posedge clock) begin
        if (!reset) begin
            variant_checked  <= 1'b0;
            variant_mismatch <= 1'b0;
        end else if (done && variant_done && !variant_checked) begin
            variant_checked <= 1'b1;
            if (variant_tohost != shadow) variant_mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// Bench for tohost_monitor: directed literal checks plus randomized beats against a cycle-level model.
module tb_tohost_monitor;

    localparam logic [31:0] TA = 32'h8000_1000;
    localparam int          AD = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_mask = '0;
    logic [63:0] max_cycles = '0;
    logic [63:0] tohost;
    logic        cmd_valid;
    logic [63:0] cmd_data;
    logic        done, pass, fail, timeout;
    logic [62:0] exit_code;
    logic [63:0] cycle_count;
`ifdef TOHOST_VARIANT_CMP_EN
    logic        variant_done = 1'b0;
    logic [63:0] variant_tohost = '0;
    logic        variant_mismatch;
`endif

    tohost_monitor #(.TOHOST_ADDR(TA), .ACK_DELAY(AD)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .max_cycles(max_cycles),
        .tohost(tohost), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .exit_code(exit_code), .cycle_count(cycle_count)
`ifdef TOHOST_VARIANT_CMP_EN
        , .variant_done(variant_done), .variant_tohost(variant_tohost),
        .variant_mismatch(variant_mismatch)
`endif
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the host harness sees, advanced once per rising edge.
    bit [63:0] m_sh, m_cnt, m_cmd_d, m_old_cnt;
    bit [62:0] m_exit;
    bit        m_done, m_pass, m_fail, m_tmo, m_cmd_v, m_eval, m_started;
    int        m_busy;

    always @(posedge clock) begin
        if (!reset) begin
            m_sh = '0; m_cnt = '0; m_cmd_d = '0; m_exit = '0;
            m_done = 0; m_pass = 0; m_fail = 0; m_tmo = 0; m_cmd_v = 0;
            m_eval = 0; m_busy = 0;
        end else begin
            m_old_cnt = m_cnt;
            m_cmd_v = 0;
            if (!m_done && m_cnt != '1) m_cnt = m_cnt + 1;
            if (m_done) begin
            end else if (m_eval) begin
                m_eval = 0;
                if (m_sh[0]) begin
                    m_done = 1;
                    m_pass = (m_sh == 64'd1);
                    m_fail = !m_pass;
                    m_exit = m_sh[63:1];
                end else begin
                    m_cmd_v = 1;
                    m_cmd_d = m_sh;
                    m_busy  = AD;
                end
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_sh = '0;
            end else if (wr_valid && wr_addr == TA) begin
                for (int b = 0; b < 8; b++)
                    if (wr_mask[b]) m_sh[8*b +: 8] = wr_data[8*b +: 8];
                if (m_sh != 0) m_eval = 1;
            end else if (max_cycles != 0 && m_old_cnt >= max_cycles) begin
                m_tmo = 1; m_fail = 1; m_done = 1;
            end
        end
        m_started = 1;
    end

    always @(negedge clock) begin
        if (m_started) begin
            chk("m_wr_ready",    {63'd0, wr_ready}, {63'd0, m_done || (!m_eval && m_busy == 0)});
            chk("m_tohost",      tohost, m_sh);
            chk("m_cmd_valid",   {63'd0, cmd_valid}, {63'd0, m_cmd_v});
            chk("m_cmd_data",    cmd_data, m_cmd_d);
            chk("m_done",        {63'd0, done}, {63'd0, m_done});
            chk("m_pass",        {63'd0, pass}, {63'd0, m_pass});
            chk("m_fail",        {63'd0, fail}, {63'd0, m_fail});
            chk("m_timeout",     {63'd0, timeout}, {63'd0, m_tmo});
            chk("m_exit_code",   {1'b0, exit_code}, {1'b0, m_exit});
            chk("m_cycle_count", cycle_count, m_cnt);
        end
    end

    task automatic do_reset(input logic [63:0] mc);
        @(negedge clock);
        reset = 1'b0;
        wr_valid = 1'b0;
        max_cycles = mc;
        @(negedge clock);
        chk("rst_wr_ready", {63'd0, wr_ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_tohost", tohost, 64'd0);
        chk("rst_cycle_count", cycle_count, 64'd0);
        reset = 1'b1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        @(negedge clock);
        wr_valid = 1'b0;
    endtask

    int zeros, seen_cmd;

    initial begin
        // Pass exit
        do_reset(0);
        @(negedge clock);
        chk("cnt_first", cycle_count, 64'd1);
        beat(TA, 64'd1, 8'hFF);
        chk("pass_shadow", tohost, 64'd1);
        chk("pass_not_yet", {63'd0, done}, 64'd0);
        @(negedge clock);
        chk("pass_done", {63'd0, done}, 64'd1);
        chk("pass_pass", {63'd0, pass}, 64'd1);
        chk("pass_fail", {63'd0, fail}, 64'd0);
        chk("pass_exit", {1'b0, exit_code}, 64'd0);

        // Fail exit, later write ignored
        do_reset(0);
        beat(TA, 64'd7, 8'hFF);
        @(negedge clock);
        chk("f7_fail", {63'd0, fail}, 64'd1);
        chk("f7_exit", {1'b0, exit_code}, 64'd3);
        chk("f7_pass", {63'd0, pass}, 64'd0);
        beat(TA, 64'd1, 8'hFF);
        @(negedge clock);
        chk("f7_frozen_tohost", tohost, 64'd7);
        chk("f7_frozen_pass", {63'd0, pass}, 64'd0);
        chk("f7_frozen_exit", {1'b0, exit_code}, 64'd3);

        // Command and host ack
        do_reset(0);
        beat(TA, 64'h0000_0000_0101_0000, 8'hFF);
        zeros = 0; seen_cmd = 0;
        for (int k = 0; k < 20; k++) begin
            if (wr_ready) break;
            zeros++;
            if (cmd_valid) begin
                seen_cmd++;
                chk("cmd_data", cmd_data, 64'h0000_0000_0101_0000);
            end
            @(negedge clock);
        end
        chk("ack_busy_cycles", zeros, 64'd5);
        chk("cmd_pulses", seen_cmd, 64'd1);
        chk("ack_cleared", tohost, 64'd0);
        chk("ack_done", {63'd0, done}, 64'd0);

        // Split write: first half already an exit
        do_reset(0);
        beat(TA, 64'd3, 8'h0F);
        @(negedge clock);
        chk("split_exit", {1'b0, exit_code}, 64'd1);
        chk("split_fail", {63'd0, fail}, 64'd1);
        beat(TA, 64'h0000_0005_0000_0000, 8'hF0);
        chk("split_dropped", tohost, 64'd3);

        // Timeout
        do_reset(100);
        for (int k = 0; k < 300; k++) begin
            if (cycle_count == 64'd100) break;
            @(negedge clock);
        end
        chk("tmo_reach", cycle_count, 64'd100);
        chk("tmo_not_early", {63'd0, done}, 64'd0);
        @(negedge clock);
        chk("tmo_timeout", {63'd0, timeout}, 64'd1);
        chk("tmo_fail", {63'd0, fail}, 64'd1);
        chk("tmo_done", {63'd0, done}, 64'd1);
        chk("tmo_exit", {1'b0, exit_code}, 64'd0);

        // Beat wins over timeout in the same cycle
        do_reset(100);
        for (int k = 0; k < 300; k++) begin
            if (cycle_count == 64'd100) break;
            @(negedge clock);
        end
        beat(TA, 64'd1, 8'hFF);
        chk("race_no_tmo", {63'd0, timeout}, 64'd0);
        chk("race_shadow", tohost, 64'd1);
        @(negedge clock);
        chk("race_pass", {63'd0, pass}, 64'd1);
        chk("race_tmo_after", {63'd0, timeout}, 64'd0);

        // Reset mid ACK_WAIT
        do_reset(0);
        beat(TA, 64'h10, 8'hFF);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_ready", {63'd0, wr_ready}, 64'd1);
        chk("midrst_tohost", tohost, 64'd0);
        chk("midrst_cmd", {63'd0, cmd_valid}, 64'd0);
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("midrst_idle_ready", {63'd0, wr_ready}, 64'd1);
        end
        beat(TA, 64'd1, 8'hFF);
        @(negedge clock);
        chk("midrst_then_pass", {63'd0, pass}, 64'd1);

        // Randomized traffic against the model
        for (int r = 0; r < 14; r++) begin
            do_reset(($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(10, 120)));
            for (int c = 0; c < 250; c++) begin
                int sel;
                if ($urandom_range(0, 149) == 0) reset = 1'b0; else reset = 1'b1;
                wr_valid = ($urandom_range(0, 1) == 1);
                wr_addr = ($urandom_range(0, 2) != 0) ? TA : (TA + 32'($urandom_range(1, 16)) * 32'd8);
                sel = $urandom_range(0, 5);
                case (sel)
                    0: wr_data = 64'd1;
                    1: wr_data = {$urandom, $urandom} | 64'd1;
                    2: wr_data = {$urandom, $urandom} & ~64'd1;
                    3: wr_data = 64'd0;
                    4: wr_data = {$urandom, $urandom};
                    default: wr_data = 64'd3;
                endcase
                sel = $urandom_range(0, 3);
                case (sel)
                    0: wr_mask = 8'hFF;
                    1: wr_mask = 8'h00;
                    default: wr_mask = 8'($urandom);
                endcase
                @(negedge clock);
            end
            reset = 1'b1;
            wr_valid = 1'b0;
        end

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
